// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external WIDTH-bit adder among N_REQ requesters.
// Latency: req sampled in IDLE -> gnt next cycle (CALC) -> res_valid the cycle after; 3 cycles per op.
// Backpressure: res_ready low holds the result in HOLD indefinitely; req is not sampled until IDLE.
module adder_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   a_in,
   input  logic [N_REQ*WIDTH-1:0]   b_in,
   output logic [N_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH:0]           add_sum,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH:0]           res_sum,
   output logic [IDW-1:0]           res_id,
   output logic                     busy,
   output logic [7:0]               op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   int unsigned      cand;

   // Round-robin search: first asserted req starting at rr_ptr, wrapping upward.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % N_REQ;
         if (!win_found && req[IDW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDW'(cand);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state: one grant per op, HOLD waits for the consumer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = CALC;
         CALC:    state_nxt = HOLD;
         HOLD:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Busy follows the registered state, so it covers the gnt cycle through the handshake cycle.
   assign busy = (state != IDLE);

   // Operand latch, grant pulse, result capture, pointer advance and completion count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         res_sum   <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
         rr_ptr    <= '0;
         op_count  <= '0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  add_a  <= a_in[int'(win_idx)*WIDTH +: WIDTH];
                  add_b  <= b_in[int'(win_idx)*WIDTH +: WIDTH];
                  res_id <= win_idx;
                  gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                  rr_ptr <= (win_idx == IDW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
               end
            end
            CALC: begin
               res_sum   <= add_sum;
               res_valid <= 1'b1;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (op_count != 8'hFF) op_count <= op_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: table of arbitration vectors plus hand-written sequences.
// The shared adder is modelled here as a plain combinational add of the DUT operand outputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_adder_share_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_in, b_in;
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       add_a, add_b;
   logic [WIDTH:0]         add_sum;
   logic                   res_valid, res_ready;
   logic [WIDTH:0]         res_sum;
   logic [IDW-1:0]         res_id;
   logic                   busy;
   logic [7:0]             op_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign add_sum = {1'b0, add_a} + {1'b0, add_b};

   adder_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_id(res_id), .busy(busy), .op_count(op_count)
   );

   typedef struct {
      logic [3:0]  req;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  id;
      logic [4:0]  sum;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advances at least one cycle, then waits (bounded) for a grant pulse.
   task automatic wait_gnt(output int cyc);
      cyc = 1;
      tick();
      while (gnt == '0 && cyc < 20) begin
         tick();
         cyc++;
      end
      if (gnt == '0) begin
         n_vec++;
         n_err++;
         $display("FAIL gnt_timeout: no grant within %0d cycles", cyc);
      end
   endtask

   initial begin
      int c;
      logic [4:0] held_sum;
      logic [1:0] held_id;

      //             req      a         b        id     sum
      vecs[0] = '{4'b0100, 16'h4F62, 16'h7153, 2'd2, 5'h10};
      vecs[1] = '{4'b0011, 16'h5327, 16'h6498, 2'd0, 5'h0F};
      vecs[2] = '{4'b1010, 16'h1B9C, 16'h2390, 2'd1, 5'h12};
      vecs[3] = '{4'b1001, 16'hC512, 16'hD634, 2'd3, 5'h19};
      vecs[4] = '{4'b1111, 16'h8760, 16'h5430, 2'd0, 5'h00};
      vecs[5] = '{4'b1000, 16'hF123, 16'hF456, 2'd3, 5'h1E};

      reset = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
      tick(); tick();
      check("rst_gnt",       32'(gnt),       32'h0);
      check("rst_add_a",     32'(add_a),     32'h0);
      check("rst_add_b",     32'(add_b),     32'h0);
      check("rst_res_sum",   32'(res_sum),   32'h0);
      check("rst_res_id",    32'(res_id),    32'h0);
      check("rst_res_valid", 32'(res_valid), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_op_count",  32'(op_count),  32'h0);
      reset = 1'b0;

      // Single request with exact cycle timing.
      req = 4'b0001; a_in = 16'h0005; b_in = 16'h0009; res_ready = 1'b1;
      tick();
      check("single_gnt",   32'(gnt),       32'h1);
      check("single_busy",  32'(busy),      32'h1);
      check("single_nvld",  32'(res_valid), 32'h0);
      req = '0;
      tick();
      check("single_vld",   32'(res_valid), 32'h1);
      check("single_sum",   32'(res_sum),   32'h0E);
      check("single_id",    32'(res_id),    32'h0);
      check("single_gnt0",  32'(gnt),       32'h0);
      tick();
      check("single_done",  32'(res_valid), 32'h0);
      check("single_idle",  32'(busy),      32'h0);
      check("single_count", 32'(op_count),  32'h1);

      // Arbitration table; rr_ptr carries over from vector to vector.
      for (int i = 0; i < 6; i++) begin
         req = vecs[i].req; a_in = vecs[i].a; b_in = vecs[i].b;
         wait_gnt(c);
         check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(4'b0001 << vecs[i].id));
         req = '0;
         tick();
         check($sformatf("vec%0d_vld", i), 32'(res_valid), 32'h1);
         check($sformatf("vec%0d_id", i),  32'(res_id),    32'(vecs[i].id));
         check($sformatf("vec%0d_sum", i), 32'(res_sum),   32'(vecs[i].sum));
         tick();
      end
      check("table_count", 32'(op_count), 32'd7);

      // All four requesting continuously: order 0,1,2,3,0, one grant every 3 cycles.
      req = 4'b1111; a_in = 16'h1111; b_in = 16'h2222;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(c);
         check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
         if (g > 0) check($sformatf("rr%0d_gap", g), 32'(c), 32'd3);
      end
      req = '0;
      tick(); tick();
      check("rr_count", 32'(op_count), 32'd12);

      // Backpressure: rr_ptr is 1, only requester 0 asks.
      res_ready = 1'b0; req = 4'b0001; a_in = 16'h0003; b_in = 16'h0004;
      wait_gnt(c);
      check("bp_gnt", 32'(gnt), 32'h1);
      req = 4'b0010;
      tick();
      held_sum = res_sum; held_id = res_id;
      check("bp_sum", 32'(held_sum), 32'h07);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_hold%0d", k),
               32'({res_valid, res_sum, res_id, gnt, busy}),
               32'({1'b1, held_sum, held_id, 4'b0000, 1'b1}));
         tick();
      end
      res_ready = 1'b1; req = '0;
      tick();
      check("bp_release_vld",  32'(res_valid), 32'h0);
      check("bp_release_busy", 32'(busy),      32'h0);
      check("bp_count",        32'(op_count),  32'd13);
      tick();
      check("bp_no_gnt", 32'(gnt), 32'h0);

      // Reset while gnt is high: grant drops without waiting for a clock.
      res_ready = 1'b0; req = 4'b0100; a_in = 16'h0300; b_in = 16'h0200;
      wait_gnt(c);
      check("rcalc_gnt", 32'(gnt), 32'h4);
      #2 reset = 1'b1;
      #1;
      check("rcalc_gnt0", 32'(gnt),  32'h0);
      check("rcalc_busy", 32'(busy), 32'h0);
      req = '0;
      @(posedge clk); #1 reset = 1'b0;

      // Reset while holding a result.
      req = 4'b0010; a_in = 16'h0050; b_in = 16'h0060;
      wait_gnt(c);
      req = '0;
      tick();
      check("rhold_vld", 32'(res_valid), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("rhold_async", 32'({res_valid, gnt, busy}), 32'h0);
      check("rhold_count", 32'(op_count), 32'h0);
      req = 4'b1000; a_in = 16'h6000; b_in = 16'h7000;
      @(posedge clk); #1 reset = 1'b0;
      wait_gnt(c);
      check("post_rst_gnt", 32'(gnt), 32'h8);
      req = '0;
      tick();
      check("post_rst_id",  32'(res_id),  32'h3);
      check("post_rst_sum", 32'(res_sum), 32'h0D);
      res_ready = 1'b1;
      tick();

      // Saturation: requester 0 held, back-to-back ops from a clean reset.
      reset = 1'b1; req = 4'b0001; a_in = 16'h0001; b_in = 16'h0001; res_ready = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      repeat (3*254) tick();
      check("sat_254", 32'(op_count), 32'd254);
      repeat (3) tick();
      check("sat_255", 32'(op_count), 32'd255);
      repeat (18) tick();
      check("sat_hold", 32'(op_count), 32'd255);
      req = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that time-shares one external combinational `WIDTH`-bit adder among `N_REQ` requesters. It sits between the requesters and the shared adder datapath in the top-level wrapper. For each operation it latches the winning requester's operand pair, drives the adder, and captures the sum with carry-out. It then returns the result with the requester ID over a valid/ready output port.

## Interface

Parameters:

- `N_REQ`, 4: number of requesters, 2..8
- `WIDTH`, 4: operand width in bits
- `IDW`, 2: requester-ID width, equal to clog2(`N_REQ`)

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req`  in  `N_REQ`  per-requester request, level-sensitive
- `a_in`  in  `N_REQ*WIDTH`  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- `b_in`  in  `N_REQ*WIDTH`  operand B; same packing as `a_in`
- `gnt`  out  `N_REQ`  one-hot grant pulse; operands have been latched
- `add_a`  out  `WIDTH`  registered operand A to the shared adder
- `add_b`  out  `WIDTH`  registered operand B to the shared adder
- `add_sum`  in  `WIDTH+1`  adder result from the shared adder, {carry, sum}
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_sum`  out  `WIDTH+1`  captured {carry, sum}
- `res_id`  out  `IDW`  index of the requester that owns the result
- `busy`  out  1  high whenever the FSM is not in IDLE
- `op_count`  out  8  count of completed operations; saturates at 255

## Operation

- **FSM states:** IDLE, CALC, HOLD.
- **IDLE:**
  - If `req` != 0, select the winner by round-robin starting at `rr_ptr`.
  - Latch the winner's `a_in`/`b_in` slices into `add_a`/`add_b`.
  - Latch the winner's index into `res_id`.
  - Assert `gnt[winner]` for the next cycle, then go to CALC.
  - If `req` == 0, stay in IDLE.
- **CALC:**
  - `gnt` is high for exactly this cycle.
  - The adder settles. At the end of the cycle, `res_sum` <= `add_sum` and `res_valid` <= 1.
  - Go to HOLD.
- **HOLD:**
  - `res_valid`=1. `res_sum`, `res_id`, `add_a` and `add_b` are held stable.
  - On `res_valid` && `res_ready`: `res_valid` <= 0, `op_count` increments (saturating at 255), go to IDLE.
  - `req` is ignored in this state.
- **Round-robin pointer:**
  - After granting index i, `rr_ptr` <= (i+1) mod `N_REQ`.
  - The requester at `rr_ptr` has the highest priority; priority decreases with increasing index, wrapping.
- **Requester obligations:**
  - Hold `req` and the operands stable until `gnt` is seen.
  - Deassert `req` or present the next operands in the cycle after `gnt`.
  - The arbiter does not sample `req` during CALC or HOLD.
- **Reset values:**
  - FSM = IDLE, `rr_ptr` = 0.
  - `gnt`, `add_a`, `add_b`, `res_sum`, `res_id`, `op_count` = 0.
  - `res_valid` = 0, `busy` = 0.
- **Reset mid-operation:**
  - An in-flight or held result is discarded with no handshake.
  - `gnt` drops immediately (asynchronously).
- **Arithmetic:** `res_sum` is the unsigned `WIDTH+1`-bit value reported by the adder. The arbiter performs no modification and no overflow handling.

## Timing

- **Latency:** `req` sampled in IDLE at edge 0 → `gnt` high in cycle 1 (CALC) → `res_valid` high from edge 2.
- **Throughput:** with `res_ready` held high, one operation completes every 3 cycles (IDLE, CALC, HOLD).
- **Backpressure:** `res_ready` low stalls indefinitely in HOLD, with all outputs stable.
- **Simultaneous requests:** exactly one grant per operation. A requester still asserting `req` is re-served only after every other asserting requester has been served once.
- **`op_count`:** at 255, further completions leave it at 255.
- **`busy`:** registered from the FSM state; high from the cycle of `gnt` through the HOLD handshake cycle.

## Test plan

- **Single request:** after reset, `req`=0001, `a0`=5, `b0`=9 → `gnt`=0001 in cycle 1; `res_valid` from cycle 2 with `res_sum`=0_1110 and `res_id`=0; with `res_ready`=1, `op_count`=1.
- **Carry-out:** `a2`=15, `b2`=1 → `res_sum`=1_0000, `res_id`=2.
- **All four requesting continuously:** grant order 0,1,2,3,0 with `res_ready`=1; one `gnt` pulse every 3 cycles.
- **Backpressure:** `res_ready`=0 for 10 cycles → `res_valid`, `res_sum` and `res_id` stay constant, no new `gnt`, `busy`=1; raising `res_ready` completes the handshake and returns to IDLE.
- **Reset mid-operation:** assert `reset` during HOLD → `res_valid`, `gnt`, `busy` and `op_count` are 0 immediately; after release, `req`=1000 is granted first because `rr_ptr`=0 and no other request is pending.
- **Saturation:** 260 back-to-back operations → `op_count`=255.
